// File: rtl/part2_pkg.sv
// Shared types and constants for the part2 receive path.
// The frame is four 16-bit words: zero, {0,A}, {0,B}, A+B.
package part2_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int FRAME_LEN = 4;
  localparam int SLOT_W    = $clog2(FRAME_LEN);

  localparam logic [SLOT_W-1:0] SLOT_ZERO = 2'd0;
  localparam logic [SLOT_W-1:0] SLOT_A    = 2'd1;
  localparam logic [SLOT_W-1:0] SLOT_B    = 2'd2;
  localparam logic [SLOT_W-1:0] SLOT_SUM  = 2'd3;

  localparam int BYTE_W = 8;
  localparam int SUM_W  = 9;
  localparam int WORD_W = 16;

endpackage

// File: rtl/part2_frame_check.sv
// Combinational judge of one candidate frame.
// It also extracts A, B and the recomputed sum.
module part2_frame_check
  import part2_pkg::*;
(
  input  logic [WORD_W-1:0] frame [FRAME_LEN],
  output logic              good,
  output logic [BYTE_W-1:0] a,
  output logic [BYTE_W-1:0] b,
  output logic [SUM_W-1:0]  sum
);

  always_comb begin
    a   = frame[SLOT_A][BYTE_W-1:0];
    b   = frame[SLOT_B][BYTE_W-1:0];
    // The sum is kept at nine bits, so a carry out of A+B is part of the match.
    sum = {1'b0, a} + {1'b0, b};
    good = (frame[SLOT_ZERO] == '0)
        && (frame[SLOT_A][WORD_W-1:BYTE_W] == '0)
        && (frame[SLOT_B][WORD_W-1:BYTE_W] == '0)
        && (frame[SLOT_SUM] == {{(WORD_W-SUM_W){1'b0}}, sum});
  end

endmodule

// File: rtl/part2_rx.sv
// Frame-aligning receiver for the part2 word stream.
// It hunts for a consistent 4-word frame, then tracks slots and tolerates MISS_LIMIT-1 bad frames.
module part2_rx
  import part2_pkg::*;
#(
  parameter int MISS_LIMIT = 2,
  parameter int ERR_W      = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [WORD_W-1:0] data_in,
  output logic [BYTE_W-1:0] A_out,
  output logic [BYTE_W-1:0] B_out,
  output logic [SUM_W-1:0]  Sum_out,
  output logic              frame_valid,
  output logic              locked,
  output logic [ERR_W-1:0]  err_count
);

  localparam int MISS_W = 4;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [MISS_W-1:0]   miss_inc;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [BYTE_W-1:0]   a_q, a_d, b_q, b_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                fv_q, fv_d;
  logic                locked_q, locked_d;
  logic [WORD_W-1:0]   win_q [FRAME_LEN-1];
  logic [WORD_W-1:0]   win_d [FRAME_LEN-1];

  logic [WORD_W-1:0]   frame [FRAME_LEN];
  logic                good;
  logic [BYTE_W-1:0]   chk_a, chk_b;
  logic [SUM_W-1:0]    chk_sum;

  // Three stored words plus the live input form the candidate frame.
  for (genvar gi = 0; gi < FRAME_LEN - 1; gi++) begin : g_frame
    assign frame[gi] = win_q[gi];
  end
  assign frame[SLOT_SUM] = data_in;

  part2_frame_check u_check (
    .frame (frame),
    .good  (good),
    .a     (chk_a),
    .b     (chk_b),
    .sum   (chk_sum)
  );

  assign miss_inc = miss_q + MISS_W'(1);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    miss_d  = miss_q;
    err_d   = err_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    fv_d    = 1'b0;
    win_d[0] = win_q[1];
    win_d[1] = win_q[2];
    win_d[2] = data_in;

    case (state_q)
      HUNT: begin
        slot_d = SLOT_ZERO;
        if (good) begin
          state_d = LOCKED;
          a_d     = chk_a;
          b_d     = chk_b;
          sum_d   = chk_sum;
          fv_d    = 1'b1;
          miss_d  = '0;
        end
      end
      LOCKED: begin
        slot_d = slot_q + SLOT_W'(1);
        if (slot_q == SLOT_SUM) begin
          if (good) begin
            a_d    = chk_a;
            b_d    = chk_b;
            sum_d  = chk_sum;
            fv_d   = 1'b1;
            miss_d = '0;
          end else begin
            if (err_q != '1) begin
              err_d = err_q + ERR_W'(1);
            end
            if (miss_inc == MISS_W'(MISS_LIMIT)) begin
              state_d = HUNT;
              slot_d  = SLOT_ZERO;
              miss_d  = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q  <= HUNT;
      slot_q   <= SLOT_ZERO;
      miss_q   <= '0;
      err_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      fv_q     <= 1'b0;
      locked_q <= 1'b0;
      for (int i = 0; i < FRAME_LEN - 1; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      fv_q     <= fv_d;
      locked_q <= locked_d;
      for (int i = 0; i < FRAME_LEN - 1; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign A_out       = a_q;
  assign B_out       = b_q;
  assign Sum_out     = sum_q;
  assign frame_valid = fv_q;
  assign locked      = locked_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_part2_rx.sv
// Directed bench for part2_rx: a default instance plus a narrow-counter, high-tolerance
// instance fed the same stream.
module tb_part2_rx;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [15:0] data_in;

  logic [7:0]  a1, b1, a2, b2;
  logic [8:0]  s1, s2;
  logic        fv1, fv2, lk1, lk2;
  logic [7:0]  err1;
  logic [1:0]  err2;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  always #5 Clock = ~Clock;

  part2_rx #(.MISS_LIMIT(2), .ERR_W(8)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .data_in     (data_in),
    .A_out       (a1),
    .B_out       (b1),
    .Sum_out     (s1),
    .frame_valid (fv1),
    .locked      (lk1),
    .err_count   (err1)
  );

  part2_rx #(.MISS_LIMIT(15), .ERR_W(2)) dut_sat (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .data_in     (data_in),
    .A_out       (a2),
    .B_out       (b2),
    .Sum_out     (s2),
    .frame_valid (fv2),
    .locked      (lk2),
    .err_count   (err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [15:0] w);
    data_in = w;
    @(posedge Clock);
    #1;
  endtask

  // Slots 0..2 must never pulse frame_valid in these sequences.
  task automatic send_frame(input string tag, input logic [15:0] w1, input logic [15:0] w2,
                            input logic [15:0] w3);
    step(16'h0000);
    check({tag, "_fv_w0"}, fv1, 0);
    step(w1);
    check({tag, "_fv_w1"}, fv1, 0);
    step(w2);
    check({tag, "_fv_w2"}, fv1, 0);
    step(w3);
  endtask

  initial begin
    Resetn  = 1'b0;
    data_in = 16'hFFFF;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    check("rst_a", a1, 0);
    check("rst_b", b1, 0);
    check("rst_sum", s1, 0);
    check("rst_fv", fv1, 0);
    check("rst_locked", lk1, 0);
    check("rst_err", err1, 0);
    check("rst_err_sat", err2, 0);

    Resetn = 1'b1;
    step(16'hFFFF);
    check("leadin_locked", lk1, 0);

    send_frame("f1", 16'h0012, 16'h0034, 16'h0046);
    check("f1_fv", fv1, 1);
    check("f1_locked", lk1, 1);
    check("f1_a", a1, 8'h12);
    check("f1_b", b1, 8'h34);
    check("f1_sum", s1, 9'h046);
    check("f1_locked_sat", lk2, 1);

    send_frame("f2", 16'h0012, 16'h0034, 16'h0046);
    check("f2_fv", fv1, 1);

    send_frame("max", 16'h00FF, 16'h00FF, 16'h01FE);
    check("max_fv", fv1, 1);
    check("max_a", a1, 8'hFF);
    check("max_b", b1, 8'hFF);
    check("max_sum", s1, 9'h1FE);
    check("max_err", err1, 0);

    send_frame("bad1", 16'h0012, 16'h0034, 16'h0047);
    check("bad1_fv", fv1, 0);
    check("bad1_err", err1, 1);
    check("bad1_locked", lk1, 1);
    check("bad1_a_hold", a1, 8'hFF);
    check("bad1_sum_hold", s1, 9'h1FE);
    check("bad1_err_sat", err2, 1);

    send_frame("good", 16'h0012, 16'h0034, 16'h0046);
    check("good_fv", fv1, 1);
    check("good_err", err1, 1);
    check("good_a", a1, 8'h12);

    send_frame("bad2", 16'h0012, 16'h0034, 16'h0047);
    check("bad2_fv", fv1, 0);
    check("bad2_err", err1, 2);
    check("bad2_locked", lk1, 1);

    send_frame("bad3", 16'h0012, 16'h0034, 16'h0047);
    check("bad3_err", err1, 3);
    check("bad3_locked", lk1, 0);
    check("bad3_a_hold", a1, 8'h12);
    check("bad3_sum_hold", s1, 9'h046);
    check("bad3_err_sat", err2, 3);
    check("bad3_locked_sat", lk2, 1);

    send_frame("relock", 16'h0012, 16'h0034, 16'h0046);
    check("relock_fv", fv1, 1);
    check("relock_locked", lk1, 1);
    check("relock_fv_sat", fv2, 1);

    send_frame("bad4", 16'h0012, 16'h0034, 16'h0047);
    send_frame("bad5", 16'h0012, 16'h0034, 16'h0047);
    check("bad5_err", err1, 5);
    check("bad5_locked", lk1, 0);
    check("bad5_err_sat", err2, 3);
    check("bad5_locked_sat", lk2, 1);

    send_frame("relock2", 16'h0012, 16'h0034, 16'h0046);
    check("relock2_locked", lk1, 1);

    // Reset lands on the slot-2 word of a frame.
    step(16'h0000);
    step(16'h0012);
    Resetn = 1'b0;
    step(16'h0034);
    check("midrst_a", a1, 0);
    check("midrst_sum", s1, 0);
    check("midrst_locked", lk1, 0);
    check("midrst_err", err1, 0);
    check("midrst_err_sat", err2, 0);
    Resetn = 1'b1;
    step(16'h0046);
    check("midrst_tail_fv", fv1, 0);
    check("midrst_tail_locked", lk1, 0);
    send_frame("midrst_relock", 16'h0012, 16'h0034, 16'h0046);
    check("midrst_relock_fv", fv1, 1);
    check("midrst_relock_a", a1, 8'h12);

    Resetn = 1'b0;
    step(16'hFFFF);
    Resetn = 1'b1;
    step(16'h00FF);
    step(16'h01FE);
    check("mis_locked_a", lk1, 0);
    step(16'h0000);
    step(16'h0005);
    step(16'h000A);
    check("mis_locked_b", lk1, 0);
    check("mis_fv_b", fv1, 0);
    step(16'h000F);
    check("mis_fv", fv1, 1);
    check("mis_locked", lk1, 1);
    check("mis_a", a1, 8'h05);
    check("mis_b", b1, 8'h0A);
    check("mis_sum", s1, 9'h00F);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/part2_rx.md
Name: part2_rx

Overview:
Receive side of the 4-slot word stream produced by the part2 datapath: {0x0000, {8'h00,A}, {8'h00,B}, A+B}, one 16-bit word per Clock, repeating.
Finds frame alignment without a sync strobe, recovers A, B and Sum, and checks each frame for consistency.
Sits directly on the transmitter's data_out, in the same Clock domain, and feeds downstream display/compare logic.

Parameters:
MISS_LIMIT, 2, consecutive bad frames while LOCKED before dropping back to HUNT (range 1..15)
ERR_W, 8, width of the saturating bad-frame counter

Ports:
Clock  input  1  system clock; all state updates on posedge
Resetn  input  1  synchronous reset, active-low
data_in  input  16  incoming word stream, sampled every posedge
A_out  output  8  recovered A from the last good frame
B_out  output  8  recovered B from the last good frame
Sum_out  output  9  recovered A+B from the last good frame
frame_valid  output  1  one-cycle pulse per accepted frame
locked  output  1  high while in the LOCKED state
err_count  output  ERR_W  saturating count of bad frames seen while LOCKED

Behaviour:
- Reset: Resetn=0 at a posedge clears everything, including mid-frame state. State=HUNT, slot=0, window cleared, miss=0. Outputs A_out=0, B_out=0, Sum_out=0, frame_valid=0, locked=0, err_count=0.
- Window: three-entry shift register w0,w1,w2, holding the oldest to newest prior words. It shifts in data_in every cycle in both states.
- Frame check is combinational on {w0, w1, w2, data_in}. The frame is good iff all four hold:
  - w0==0
  - w1[15:8]==0
  - w2[15:8]==0
  - data_in == {7'b0, w1[7:0]+w2[7:0]}, using a 9-bit sum with no truncation.
- HUNT:
  - The check is evaluated every cycle.
  - On a good check, the next posedge moves to LOCKED, sets slot so the next word is slot 0, loads A_out=w1[7:0], B_out=w2[7:0], Sum_out=data_in[8:0], and pulses frame_valid.
  - A bad check in HUNT does not touch err_count.
- LOCKED:
  - A 2-bit slot counter increments per cycle and wraps 3->0.
  - The check is evaluated only when slot==3 (data_in is W3).
  - Good frame: load outputs as above, pulse frame_valid, clear miss.
  - Bad frame: outputs hold, frame_valid=0, err_count+1 (saturating at all-ones), miss+1.
  - If miss reaches MISS_LIMIT, the next posedge goes to HUNT, locked=0, miss=0. A_out, B_out and Sum_out hold their last good values.
- Latency: frame_valid is high in the cycle immediately after W3 was present on data_in (one posedge).
- An all-zero stream (A=B=0) validates at any offset. This is accepted: the recovered values are identical at every alignment.
- Slots 1 and 2 are never checked in isolation. Only the whole frame is judged, at slot 3.

Decomposition:
- Package part2_pkg holds:
  - the state enum {HUNT, LOCKED}
  - FRAME_LEN=4
  - slot constants SLOT_ZERO=0, SLOT_A=1, SLOT_B=2, SLOT_SUM=3
  - the 8/9/16-bit width constants
- One natural sub-module: part2_frame_check, purely combinational. It takes {w0, w1, w2, w3} and returns good plus the extracted A, B and Sum.
- The FSM, window, slot, miss and err counters stay in part2_rx.

Test Plan:
- Clean stream, aligned start, A=0x12, B=0x34 (words 0000,0012,0034,0046 repeated) -> locked and frame_valid one cycle after the first 0046. A_out=12, B_out=34, Sum_out=046. frame_valid every 4 cycles thereafter.
- Max values A=B=0xFF (0000,00FF,00FF,01FE) -> Sum_out=1FE, no overflow, err_count stays 0.
- Misaligned start: first words 00FF,01FE, then a full frame with A=0x05, B=0x0A -> no lock until after the 000F word. Then A_out=05, B_out=0A, Sum_out=00F.
- While locked, corrupt one W3 (0047 instead of 0046) -> no pulse that frame, err_count=1, locked stays 1. Next good frame pulses and clears miss.
- Two consecutive corrupted W3 with MISS_LIMIT=2 -> err_count=2, locked drops after the second. The first later clean frame relocks with one frame_valid.
- Resetn=0 for one cycle mid-frame (at slot 2) -> all outputs 0, HUNT. Relock after the next complete frame.
- ERR_W=2 with five bad frames and MISS_LIMIT=15 -> err_count saturates at 3.
